// File: rtl/div_subshift_signed_pkg.sv
// Shared definitions for the sequential shift-subtract divider: FSM state
// encodings and the sizing rule for the iteration counter.
package div_subshift_signed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must hold the value DATA_W itself, hence the +1.
    function automatic int iter_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/div_subshift_signed_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_subshift_signed_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;
    logic            borrow;

    // The remainder stays below the divisor, so a nonnegative difference
    // always has a clear top bit and a negative one always has it set.
    always_comb begin
        partial = {rem_in, quo_in[DATA_W-1]};
        diff    = partial - {1'b0, divisor};
        borrow  = diff[DATA_W];
        rem_out = borrow ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_out = {quo_in[DATA_W-2:0], ~borrow};
    end

endmodule

// File: rtl/div_subshift_signed.sv
// Multi-cycle signed/unsigned divider with valid/ready handshakes; magnitudes
// are divided one bit per cycle and the signs are restored in a fix-up cycle.
module div_subshift_signed
    import div_subshift_signed_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_en,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CNT_W = iter_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  iter_cnt;
    logic [DATA_W-1:0] rem_acc;
    logic [DATA_W-1:0] quo_acc;
    logic [DATA_W-1:0] divisor_abs;
    logic              q_neg;
    logic              r_neg;

    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] dividend_abs_in;
    logic [DATA_W-1:0] divisor_abs_in;
    logic              divisor_zero;
    logic              dividend_neg;
    logic              divisor_neg;

    always_comb begin
        dividend_neg    = sign_en & dividend[DATA_W-1];
        divisor_neg     = sign_en & divisor[DATA_W-1];
        dividend_abs_in = dividend_neg ? -dividend : dividend;
        divisor_abs_in  = divisor_neg ? -divisor : divisor;
        divisor_zero    = (divisor == '0);
    end

    div_subshift_signed_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_in  (rem_acc),
        .quo_in  (quo_acc),
        .divisor (divisor_abs),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (iter_cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand and mode registers only load in IDLE; the result registers only
    // load on a zero-divisor accept or in FIX, so they hold everywhere else.
    // MIN / -1 needs no special case: |MIN| / 1 = MIN, and negating MIN is MIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt    <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            divisor_abs <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            iter_cnt    <= '0;
                            rem_acc     <= '0;
                            quo_acc     <= dividend_abs_in;
                            divisor_abs <= divisor_abs_in;
                            q_neg       <= dividend_neg ^ divisor_neg;
                            r_neg       <= dividend_neg;
                        end
                    end
                end
                CALC: begin
                    rem_acc  <= rem_next;
                    quo_acc  <= quo_next;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient    <= q_neg ? -quo_acc : quo_acc;
                    remainder   <= r_neg ? -rem_acc : rem_acc;
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_subshift_signed.sv
// Directed bench for the 8-bit divider: handshake latency, signed/unsigned
// results, divide-by-zero, backpressure and mid-operation reset.
module tb_div_subshift_signed;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       sign_en;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_compared = 0;
    int n_mismatch = 0;
    int lat;

    div_subshift_signed #(
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign_en     (sign_en),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request; the edge consumed here is the accept edge T.
    task automatic apply_stimulus(input logic s, input logic [7:0] a, input logic [7:0] b);
        sign_en  = s;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_in_ready_low", in_ready, 1'b0);
    endtask

    // Latency is counted as the edge at which out_valid is first sampled high.
    task automatic wait_result(output int latency);
        int cycles;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        latency = cycles + 1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic dbz, input int exp_lat, input int got_lat);
        check({tag, "_latency"}, 64'(got_lat), 64'(exp_lat));
        check({tag, "_quotient"}, quotient, q);
        check({tag, "_remainder"}, remainder, r);
        check({tag, "_div_by_zero"}, div_by_zero, dbz);
    endtask

    task automatic pop_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_pop_out_valid"}, out_valid, 1'b0);
        check({tag, "_pop_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r, input logic dbz, input int exp_lat);
        int l;
        apply_stimulus(s, a, b);
        wait_result(l);
        check_output(tag, q, r, dbz, exp_lat, l);
        pop_result(tag);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        sign_en   = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;

        #2;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_quotient", quotient, 8'h00);
        check("reset_remainder", remainder, 8'h00);
        check("reset_div_by_zero", div_by_zero, 1'b0);
        check("reset_counter", dut.iter_cnt, 0);
        #1;
        rst = 1'b1;

        // First accept lands on the first rising edge after release.
        run_op("u_100_7", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10);
        run_op("s_m7_2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
        run_op("s_min_m1", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
        run_op("dbz_2a", 1'b0, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1);
        run_op("u_f9_2", 1'b0, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0, 10);
        run_op("s_100_m7", 1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 10);
        run_op("s_m100_m7", 1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 10);
        run_op("u_ff_1", 1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 10);
        run_op("dbz_signed", 1'b1, 8'h85, 8'h00, 8'hFF, 8'h85, 1'b1, 1);
        run_op("u_5_9", 1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 10);

        // Backpressure: result must hold and new requests must be ignored.
        apply_stimulus(1'b0, 8'd200, 8'd11);
        wait_result(lat);
        check_output("hold", 8'h12, 8'h02, 1'b0, 10, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sign_en  = 1'b1;
            dividend = 8'(i + 3);
            divisor  = (i == 2) ? 8'h00 : 8'h01;
            @(posedge clk);
            #1;
            check("hold_quotient", quotient, 8'h12);
            check("hold_remainder", remainder, 8'h02);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        pop_result("hold");
        check("idle_keeps_quotient", quotient, 8'h12);
        check("idle_keeps_remainder", remainder, 8'h02);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("no_phantom_out_valid", out_valid, 1'b0);
        end

        // Reset during CALC clears everything at once and kills the operation.
        apply_stimulus(1'b0, 8'hF0, 8'h03);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_quotient", quotient, 8'h00);
        check("midrst_remainder", remainder, 8'h00);
        check("midrst_div_by_zero", div_by_zero, 1'b0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_out_valid", out_valid, 1'b0);
            check("post_rst_in_ready", in_ready, 1'b1);
        end
        run_op("after_rst", 1'b0, 8'hF0, 8'h03, 8'h50, 8'h00, 1'b0, 10);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
